store_buffer_unit: RTL and testbench

// - Write-side counterpart of the load-extension path: takes st.b/st.h/st.w from MEM stage, lane-aligns data,

---
 rtl/store_buffer_unit.sv | 148 ++++++++++++++
 tb/tb_store_buffer_unit.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/store_buffer_unit.sv
// Store buffer: lane-aligns st.b/st.h/st.w, queues them in a DEPTH-entry FIFO and drains to data RAM.
// Optional feature macro: STORE_FWD_EN (word-granular load hazard compare instead of conservative stall).
module store_buffer_unit #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32
) (
  input  logic                        cpu_clk,
  input  logic                        cpu_rstn,
  input  logic                        st_valid,
  output logic                        st_ready,
  input  logic [1:0]                  st_op,
  input  logic [ADDR_W-1:0]           st_addr,
  input  logic [31:0]                 st_data,
  output logic                        st_ade,
  output logic                        ram_req,
  input  logic                        ram_ack,
  output logic [ADDR_W-3:0]           ram_waddr,
  output logic [31:0]                 ram_wdata,
  output logic [3:0]                  ram_we,
  output logic                        sb_empty,
  output logic [$clog2(DEPTH+1)-1:0]  sb_cnt,
  input  logic                        ld_valid,
  input  logic [ADDR_W-1:0]           ld_addr,
  output logic                        ld_hazard
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [ADDR_W-3:0] waddr_r [DEPTH];
  logic [31:0]       wdata_r [DEPTH];
  logic [3:0]        we_r    [DEPTH];
  logic [PTR_W-1:0]  head_r;
  logic [PTR_W-1:0]  tail_r;
  logic [CNT_W-1:0]  cnt_r;

  logic [1:0]        off_s;
  logic [31:0]       al_data_s;
  logic [3:0]        al_we_s;
  logic              mis_s;
  logic              full_s;
  logic              push_s;
  logic              pop_s;

  // Lane alignment, byte-enable generation and misalignment detection
  always_comb begin
    off_s     = st_addr[1:0];
    al_data_s = 32'h0000_0000;
    al_we_s   = 4'b0000;
    mis_s     = 1'b0;
    case (st_op)
      2'b00: begin
        al_data_s = {4{st_data[7:0]}};
        al_we_s   = 4'b0001 << off_s;
      end
      2'b01: begin
        al_data_s = {2{st_data[15:0]}};
        al_we_s   = 4'b0011 << off_s;
        mis_s     = off_s[0];
      end
      2'b10: begin
        al_data_s = st_data;
        al_we_s   = 4'b1111;
        mis_s     = (off_s != 2'b00);
      end
      default: begin
        mis_s     = 1'b1;
      end
    endcase
  end

  assign full_s    = (cnt_r == CNT_W'(DEPTH));
  assign st_ready  = !full_s;
  assign st_ade    = st_valid & mis_s;
  assign push_s    = st_valid & st_ready & !st_ade;
  assign ram_req   = (cnt_r != {CNT_W{1'b0}});
  assign pop_s     = ram_req & ram_ack;
  assign sb_empty  = !ram_req;
  assign sb_cnt    = cnt_r;

  // Head entry drives the RAM port; byte enables are masked when nothing is pending
  assign ram_waddr = waddr_r[head_r];
  assign ram_wdata = wdata_r[head_r];
  assign ram_we    = ram_req ? we_r[head_r] : 4'b0000;

  // FIFO storage, pointers and occupancy
  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn) begin
      head_r <= {PTR_W{1'b0}};
      tail_r <= {PTR_W{1'b0}};
      cnt_r  <= {CNT_W{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        waddr_r[i] <= {(ADDR_W-2){1'b0}};
        wdata_r[i] <= 32'h0000_0000;
        we_r[i]    <= 4'b0000;
      end
    end else begin
      if (push_s) begin
        waddr_r[tail_r] <= st_addr[ADDR_W-1:2];
        wdata_r[tail_r] <= al_data_s;
        we_r[tail_r]    <= al_we_s;
        tail_r          <= tail_r + {{(PTR_W-1){1'b0}}, 1'b1};
      end else begin
        tail_r <= tail_r;
      end
      if (pop_s) begin
        head_r <= head_r + {{(PTR_W-1){1'b0}}, 1'b1};
      end else begin
        head_r <= head_r;
      end
      case ({push_s, pop_s})
        2'b10:   cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        2'b01:   cnt_r <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
        default: cnt_r <= cnt_r;
      endcase
    end
  end

`ifdef STORE_FWD_EN
  logic hit_s;
  logic unused_ld_s;

  assign unused_ld_s = ^ld_addr[1:0];

  // An entry is live when its distance from head is below the occupancy
  always_comb begin
    logic [PTR_W-1:0] rel;
    hit_s = 1'b0;
    rel   = {PTR_W{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      rel = PTR_W'(i) - head_r;
      if ((CNT_W'(rel) < cnt_r) && (waddr_r[i] == ld_addr[ADDR_W-1:2])) begin
        hit_s = 1'b1;
      end else begin
        hit_s = hit_s;
      end
    end
  end

  assign ld_hazard = ld_valid & hit_s;
`else
  logic unused_ld_s;

  assign unused_ld_s = ^ld_addr;
  assign ld_hazard   = ld_valid & !sb_empty;
`endif

endmodule

// File: tb/tb_store_buffer_unit.sv
// Directed self-checking bench for store_buffer_unit (DEPTH=4, ADDR_W=32).
module tb_store_buffer_unit;

  logic        cpu_clk;
  logic        cpu_rstn;
  logic        st_valid;
  logic        st_ready;
  logic [1:0]  st_op;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic        st_ade;
  logic        ram_req;
  logic        ram_ack;
  logic [29:0] ram_waddr;
  logic [31:0] ram_wdata;
  logic [3:0]  ram_we;
  logic        sb_empty;
  logic [2:0]  sb_cnt;
  logic        ld_valid;
  logic [31:0] ld_addr;
  logic        ld_hazard;

  int n_vec = 0;
  int n_err = 0;

  store_buffer_unit #(.DEPTH(4), .ADDR_W(32)) dut (
    .cpu_clk(cpu_clk), .cpu_rstn(cpu_rstn),
    .st_valid(st_valid), .st_ready(st_ready), .st_op(st_op),
    .st_addr(st_addr), .st_data(st_data), .st_ade(st_ade),
    .ram_req(ram_req), .ram_ack(ram_ack), .ram_waddr(ram_waddr),
    .ram_wdata(ram_wdata), .ram_we(ram_we),
    .sb_empty(sb_empty), .sb_cnt(sb_cnt),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_hazard(ld_hazard)
  );

  initial cpu_clk = 1'b0;
  always #5 cpu_clk = ~cpu_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge cpu_clk);
    #1;
  endtask

  task automatic push(input logic [1:0] op, input logic [31:0] addr, input logic [31:0] data);
    st_valid = 1'b1;
    st_op    = op;
    st_addr  = addr;
    st_data  = data;
    tick();
    st_valid = 1'b0;
  endtask

  task automatic ack1();
    ram_ack = 1'b1;
    tick();
    ram_ack = 1'b0;
  endtask

  // push one store into an empty buffer, check the head, then drain it
  task automatic single(input string tag, input logic [1:0] op, input logic [31:0] addr,
                        input logic [31:0] data, input logic [3:0] exp_we, input logic [31:0] exp_wd);
    push(op, addr, data);
    chk({tag, "_req"},   32'(ram_req),   32'h1);
    chk({tag, "_waddr"}, 32'(ram_waddr), addr >> 2);
    chk({tag, "_we"},    32'(ram_we),    32'(exp_we));
    chk({tag, "_wdata"}, ram_wdata,      exp_wd);
    ack1();
    chk({tag, "_drained"}, 32'(sb_empty), 32'h1);
  endtask

  task automatic bad(input string tag, input logic [1:0] op, input logic [31:0] addr);
    st_valid = 1'b1;
    st_op    = op;
    st_addr  = addr;
    st_data  = 32'h5555_AAAA;
    #1;
    chk({tag, "_ade"}, 32'(st_ade), 32'h1);
    tick();
    st_valid = 1'b0;
    chk({tag, "_cnt"}, 32'(sb_cnt),  32'h0);
    chk({tag, "_req"}, 32'(ram_req), 32'h0);
  endtask

  initial begin
    cpu_rstn = 1'b0;
    st_valid = 1'b0;
    st_op    = 2'b00;
    st_addr  = 32'h0;
    st_data  = 32'h0;
    ram_ack  = 1'b0;
    ld_valid = 1'b0;
    ld_addr  = 32'h0;
    #12;
    chk("rst_req",   32'(ram_req),   32'h0);
    chk("rst_empty", 32'(sb_empty),  32'h1);
    chk("rst_cnt",   32'(sb_cnt),    32'h0);
    chk("rst_ready", 32'(st_ready),  32'h1);
    chk("rst_we",    32'(ram_we),    32'h0);
    chk("rst_wdata", ram_wdata,      32'h0);
    chk("rst_waddr", 32'(ram_waddr), 32'h0);
    cpu_rstn = 1'b1;
    tick();

    single("st_w",  2'b10, 32'h0000_0100, 32'hDEAD_BEEF, 4'b1111, 32'hDEAD_BEEF);
    single("st_b",  2'b00, 32'h0000_0103, 32'h0000_00A5, 4'b1000, 32'hA5A5_A5A5);
    single("st_h",  2'b01, 32'h0000_0102, 32'h0000_1234, 4'b1100, 32'h1234_1234);
    single("st_b1", 2'b00, 32'h0000_0101, 32'h0000_003C, 4'b0010, 32'h3C3C_3C3C);

    bad("mis_h",  2'b01, 32'h0000_0101);
    bad("mis_w",  2'b10, 32'h0000_0102);
    bad("op_rsv", 2'b11, 32'h0000_0100);

    // load hazard against a pending store
    push(2'b10, 32'h0000_0200, 32'h1111_1111);
    ld_valid = 1'b1;
    ld_addr  = 32'h0000_0202;
    #1;
    chk("haz_same", 32'(ld_hazard), 32'h1);
    ld_addr = 32'h0000_0204;
    #1;
`ifdef STORE_FWD_EN
    chk("haz_other", 32'(ld_hazard), 32'h0);
`else
    chk("haz_other", 32'(ld_hazard), 32'h1);
`endif
    ld_valid = 1'b0;
    #1;
    chk("haz_noload", 32'(ld_hazard), 32'h0);
    ack1();
    ld_valid = 1'b1;
    #1;
    chk("haz_empty", 32'(ld_hazard), 32'h0);
    ld_valid = 1'b0;

    // fill to DEPTH with ack held low
    for (int i = 0; i < 4; i++) push(2'b10, 32'h0000_0300 + 32'(4 * i), 32'h0000_00A0 + 32'(i));
    chk("full_cnt",   32'(sb_cnt),   32'h4);
    chk("full_ready", 32'(st_ready), 32'h0);
    push(2'b10, 32'h0000_0400, 32'h0000_00FF);
    chk("full_5th_cnt",   32'(sb_cnt),    32'h4);
    chk("full_stable",    32'(ram_waddr), 32'h0000_00C0);
    chk("full_stable_wd", ram_wdata,      32'h0000_00A0);
    ack1();
    chk("ack_cnt",   32'(sb_cnt),    32'h3);
    chk("ack_ready", 32'(st_ready),  32'h1);
    chk("ack_head",  32'(ram_waddr), 32'h0000_00C1);
    push(2'b10, 32'h0000_0310, 32'h0000_00A4);
    chk("refill_cnt", 32'(sb_cnt), 32'h4);

    // full: push and ack on the same edge, push must be rejected
    ram_ack = 1'b1;
    push(2'b10, 32'h0000_0500, 32'h0000_00EE);
    ram_ack = 1'b0;
    chk("fullpp_cnt",  32'(sb_cnt),    32'h3);
    chk("fullpp_head", 32'(ram_waddr), 32'h0000_00C2);
    ack1();
    chk("cnt2", 32'(sb_cnt), 32'h2);

    // at cnt=2 push and ack together: occupancy unchanged, pointers wrap
    ram_ack = 1'b1;
    push(2'b10, 32'h0000_0320, 32'h0000_00A5);
    ram_ack = 1'b0;
    chk("pp_cnt",   32'(sb_cnt),    32'h2);
    chk("wrap0_wa", 32'(ram_waddr), 32'h0000_00C4);
    chk("wrap0_wd", ram_wdata,      32'h0000_00A4);
    ack1();
    chk("wrap1_wa", 32'(ram_waddr), 32'h0000_00C8);
    chk("wrap1_wd", ram_wdata,      32'h0000_00A5);
    ack1();
    chk("wrap_empty", 32'(sb_empty), 32'h1);
    chk("wrap_we",    32'(ram_we),   32'h0);

    // asynchronous reset in the middle of a drain
    for (int i = 0; i < 3; i++) push(2'b10, 32'h0000_0600 + 32'(4 * i), 32'h0000_0B00 + 32'(i));
    chk("mid_cnt", 32'(sb_cnt), 32'h3);
    ram_ack = 1'b1;
    #2;
    cpu_rstn = 1'b0;
    #1;
    chk("arst_req",   32'(ram_req),  32'h0);
    chk("arst_empty", 32'(sb_empty), 32'h1);
    chk("arst_cnt",   32'(sb_cnt),   32'h0);
    ram_ack = 1'b0;
    tick();
    cpu_rstn = 1'b1;
    tick();
    chk("post_rst_req", 32'(ram_req), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
